alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - RV32IM ALU operation decoder with multi-cycle MUL/DIV sequencing
// Decodes ALUOp/Funct fields into a registered operation code and holds it through MUL/DIV latency.

module alu_op_sequencer #(
  parameter int OP_W    = 5,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8,
  parameter int M_EXT   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic            ImmType,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  output logic [OP_W-1:0] Operation,
  output logic            op_valid,
  output logic            mc_busy,
  output logic            mc_done,
  output logic            illegal
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SLL  = 5'b00101;
  localparam logic [4:0] OP_SRL  = 5'b00110;
  localparam logic [4:0] OP_SRA  = 5'b00111;
  localparam logic [4:0] OP_SLT  = 5'b10000;
  localparam logic [4:0] OP_SLTU = 5'b10001;
  localparam logic [4:0] OP_PASS = 5'b10010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [4:0]       r_op, w_op_nxt;
  logic             r_op_valid, w_op_valid_nxt;
  logic             r_illegal, w_illegal_nxt;

  logic [4:0]       w_dec_op;
  logic             w_dec_ill;
  logic             w_dec_mul;
  logic             w_dec_div;

  function automatic logic [4:0] base_op(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  // Illegal encodings leave w_dec_op at its ADD default.
  always_comb begin
    w_dec_op  = OP_ADD;
    w_dec_ill = 1'b0;
    w_dec_mul = 1'b0;
    w_dec_div = 1'b0;
    case (ALUOp)
      2'b00: w_dec_op = OP_ADD;
      2'b01: begin
        if (Funct3[2:1] == 2'b01) w_dec_ill = 1'b1;
        else                      w_dec_op  = {2'b01, Funct3};
      end
      2'b10: begin
        if (ImmType) begin
          case (Funct3)
            3'b001: begin
              if (Funct7 == F7_BASE) w_dec_op  = OP_SLL;
              else                   w_dec_ill = 1'b1;
            end
            3'b101: begin
              if (Funct7 == F7_BASE)     w_dec_op  = OP_SRL;
              else if (Funct7 == F7_ALT) w_dec_op  = OP_SRA;
              else                       w_dec_ill = 1'b1;
            end
            default: w_dec_op = base_op(Funct3);
          endcase
        end else if (Funct7 == F7_BASE) begin
          w_dec_op = base_op(Funct3);
        end else if (Funct7 == F7_ALT) begin
          if (Funct3 == 3'b000)      w_dec_op  = OP_SUB;
          else if (Funct3 == 3'b101) w_dec_op  = OP_SRA;
          else                       w_dec_ill = 1'b1;
        end else if (Funct7 == F7_MEXT && M_EXT != 0) begin
          w_dec_op  = {2'b11, Funct3};
          w_dec_mul = ~Funct3[2];
          w_dec_div = Funct3[2];
        end else begin
          w_dec_ill = 1'b1;
        end
      end
      default: w_dec_op = OP_PASS;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_op_nxt       = r_op;
    w_op_valid_nxt = r_op_valid;
    w_illegal_nxt  = r_illegal;
    if (flush) begin
      w_state_nxt    = IDLE;
      w_cnt_nxt      = '0;
      w_op_valid_nxt = 1'b0;
      w_illegal_nxt  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            w_op_nxt       = w_dec_op;
            w_illegal_nxt  = w_dec_ill;
            w_op_valid_nxt = 1'b1;
            if (w_dec_mul) begin
              w_state_nxt = BUSY;
              w_cnt_nxt   = MUL_LOAD;
            end else if (w_dec_div) begin
              w_state_nxt = BUSY;
              w_cnt_nxt   = DIV_LOAD;
            end
          end else begin
            w_op_valid_nxt = 1'b0;
            w_illegal_nxt  = 1'b0;
          end
        end
        default: begin
          if (r_cnt == '0) begin
            w_state_nxt    = IDLE;
            w_op_valid_nxt = 1'b0;
            w_illegal_nxt  = 1'b0;
          end else begin
            w_cnt_nxt      = r_cnt - CNT_W'(1);
            w_op_valid_nxt = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_op_valid <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_op       <= w_op_nxt;
      r_op_valid <= w_op_valid_nxt;
      r_illegal  <= w_illegal_nxt;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign mc_busy   = (r_state == BUSY);
  // A flush in the final busy cycle suppresses the completion pulse.
  assign mc_done   = (r_state == BUSY) && (r_cnt == '0) && !flush;
  assign Operation = OP_W'(r_op);
  assign op_valid  = r_op_valid;
  assign illegal   = r_illegal;

endmodule
